// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped write-back write-allocate cache controller with hit/miss counters
module dm_cache_ctrl #(
    parameter int SETS  = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(SETS);
    localparam int TW = 32 - OW - IW;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, REFILL} state_t;

    state_t             state;
    logic               req_we;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;
    logic [OW:0]        cnt;
    logic               post_refill;
    logic               ren_q;
    logic               wen_q;
    logic [SETS-1:0]    valid;
    logic [SETS-1:0]    dirty;
    logic [TW-1:0]      tags [SETS];
    logic [31:0]        data [SETS*WORDS];
    logic [OW-1:0]      off;
    logic [IW-1:0]      idx;
    logic [TW-1:0]      tag;
    logic [OW-1:0]      nxt;
    logic [OW-1:0]      prv;
    logic               hit;

    assign off = req_addr[OW-1:0];
    assign idx = req_addr[OW+IW-1:OW];
    assign tag = req_addr[31:OW+IW];
    assign nxt = cnt[OW-1:0] + 1'b1;
    assign prv = cnt[OW-1:0] - 1'b1;
    assign hit = valid[idx] && tags[idx] == tag;
    // strobes are forced low while reset is held so the memory's reset-time load is never disturbed
    assign mem_ren = ren_q & ~rst;
    assign mem_wen = wen_q & ~rst;

    // control FSM: request capture, hit service, victim write-back and line refill sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_we      <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            cnt         <= '0;
            post_refill <= 1'b0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            valid       <= '0;
            dirty       <= '0;
            cpu_ready   <= 1'b0;
            cpu_rdata   <= '0;
            mem_addr    <= '0;
            mem_din     <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_we) dirty[idx] <= 1'b1;
                        else cpu_rdata <= data[{idx, off}];
                        if (!post_refill) hit_count <= hit_count + 1'b1;
                        post_refill <= 1'b0;
                        cpu_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        miss_count <= miss_count + 1'b1;
                        cnt        <= '0;
                        if (valid[idx] && dirty[idx]) begin
                            wen_q    <= 1'b1;
                            mem_addr <= {tags[idx], idx, {OW{1'b0}}};
                            mem_din  <= data[{idx, {OW{1'b0}}}];
                            state    <= WRITEBACK;
                        end else begin
                            ren_q    <= 1'b1;
                            mem_addr <= {tag, idx, {OW{1'b0}}};
                            state    <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (cnt[OW-1:0] == {OW{1'b1}}) begin
                        wen_q      <= 1'b0;
                        ren_q      <= 1'b1;
                        dirty[idx] <= 1'b0;
                        mem_addr   <= {tag, idx, {OW{1'b0}}};
                        cnt        <= '0;
                        state      <= REFILL;
                    end else begin
                        mem_addr <= {tags[idx], idx, nxt};
                        mem_din  <= data[{idx, nxt}];
                        cnt      <= cnt + 1'b1;
                    end
                end
                REFILL: begin
                    cnt   <= cnt + 1'b1;
                    ren_q <= cnt < (OW+1)'(WORDS - 1);
                    if (cnt < (OW+1)'(WORDS - 1)) mem_addr <= {tag, idx, nxt};
                    if (cnt == (OW+1)'(WORDS)) begin
                        valid[idx]  <= 1'b1;
                        dirty[idx]  <= 1'b0;
                        post_refill <= 1'b1;
                        state       <= COMPARE;
                    end
                end
            endcase
        end
    end

    // line storage: write hits, refill capture one cycle behind each read strobe, tag install on the last beat
    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && req_we) data[{idx, off}] <= req_wdata;
        if (state == REFILL && cnt != '0) data[{idx, prv}] <= mem_dout;
        if (state == REFILL && cnt == (OW+1)'(WORDS)) tags[idx] <= tag;
    end
endmodule
